virtio_notify_arbiter: RTL and testbench
========================================

# virtio_notify_arbiter

Synthesizable, parametrised successor of the per-queue pending-flag bookkeeping (set/clear flags for 3 fixed queues) used between the virtio CSR block and the DMA engine threads. It records queue-notify doorbells for NUM_QUEUES virtqueues, coalesces repeated doorbells per queue, and hands pending queues one at a time to the descriptor-fetch engine through a valid/ready handshake with round-robin fairness. It sits in the FIU next to `virtio_csr`, fed by the CSR queue_notify write strobe.

## Interface
Parameters:
- NUM_QUEUES, 3, number of virtqueues; legal 1..16
- QID_W, 4, width of queue-id fields; must satisfy 2**QID_W >= NUM_QUEUES
- CNT_W, 8, width of the per-queue coalesce counter (only with VIRTIO_NOTIFY_COUNT_EN)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- q_enable  in  NUM_QUEUES  per-queue enable (CSR queue_enable)
- notify_valid  in  1  doorbell strobe, at most one per cycle
- notify_qid  in  QID_W  queue id of the doorbell
- evt_valid  out  1  a pending queue is offered
- evt_qid  out  QID_W  offered queue id
- evt_ready  in  1  consumer accepts the offer
- evt_count  out  CNT_W  doorbells coalesced into the offered event (macro only)
- pending  out  NUM_QUEUES  live pending-flag vector
- drop_cnt  out  16  saturating count of dropped doorbells

## Operation
- Accepted doorbell: notify_valid=1, notify_qid<NUM_QUEUES, q_enable[qid]=1 → pending[qid] set.
- Dropped doorbell: qid>=NUM_QUEUES or queue disabled → no flag change, drop_cnt+1, saturating at 16'hFFFF.
- q_enable[q]=0 clears pending[q] (and its counter) every cycle it is low.
- FSM, two states:
  - IDLE: if any pending bit set, pick the first set bit searching upward from (last_grant+1) mod NUM_QUEUES, wrapping; register evt_qid, assert evt_valid; go OFFER. Otherwise stay.
  - OFFER: hold evt_valid=1 and evt_qid stable until evt_valid&&evt_ready; then clear pending[evt_qid], last_grant←evt_qid, drop evt_valid, go IDLE.
- Offers are never retracted: disabling the offered queue does not deassert evt_valid; the consumer checks enable itself.
- Simultaneous set and clear on the same queue (doorbell for evt_qid in the accept cycle): set wins, pending stays 1, queue becomes eligible again; no doorbell is lost.
- Doorbells to the offered queue while in OFFER merely coalesce (flag already set).
- last_grant reset value NUM_QUEUES-1, so queue 0 wins first.

## Timing
- Reset values: evt_valid=0, evt_qid=0, evt_count=0, pending=0, drop_cnt=0, FSM=IDLE.
- Doorbell in cycle T → pending visible T+1; evt_valid asserted earliest T+2 (IDLE decision in T+1, registered).
- Accept in cycle A → evt_valid=0 in A+1; next offer earliest A+2. Peak throughput: one event per 2 cycles.
- pending, drop_cnt, evt_valid, evt_qid are registered outputs; evt_count is the live counter of evt_qid.
- Asynchronous reset mid-offer: all state clears immediately; queued doorbells are lost (software re-kicks after reset).

## Configuration
- VIRTIO_NOTIFY_COUNT_EN defined: per-queue CNT_W counter increments on each accepted doorbell, saturating at all-ones; evt_count shows counter of evt_qid; on accept the counter resets to 0, or to 1 if a doorbell for that queue arrives in the accept cycle; cleared with q_enable low.
- Undefined: no counters instantiated; evt_count tied to 0.

## Test plan
- Reset: rst_n low mid-OFFER with pending=3'b111 → all outputs 0 in same cycle; after release, first doorbell to q1 gives evt_valid at T+2, evt_qid=1.
- Round-robin: doorbells to q0,q1,q2 in one burst, evt_ready=1 always → grants 0,1,2 on cycles spaced by 2, pending 3'b111→3'b000.
- Fairness/wrap: after grant q2, pending q0 and q2 → next grant q0; then q2.
- Set-wins collision: offer q1, doorbell q1 in accept cycle → pending[1] stays 1, q1 re-offered 2 cycles later; with macro, evt_count=1.
- Drops: doorbell qid=5 (NUM_QUEUES=3) and doorbell to disabled q0 → drop_cnt=2, pending unchanged; 70000 drops → drop_cnt=16'hFFFF.
- Backpressure/coalesce (macro): offer q2 held 10 cycles with evt_ready=0 while 4 further doorbells to q2 → evt_qid stable, evt_count 1→5; CNT_W=2 with 6 doorbells → evt_count saturates at 3.

Source files
------------

// File: rtl/virtio_notify_arbiter.sv
// virtio_notify_arbiter: records queue-notify doorbells per virtqueue, coalesces
// repeats, and offers pending queues one at a time to the descriptor-fetch engine
// with round-robin fairness over a valid/ready handshake.
// Optional build macro VIRTIO_NOTIFY_COUNT_EN adds a per-queue coalesce counter
// exported as evt_count; without it evt_count is tied to zero.
module virtio_notify_arbiter #(
  parameter int NUM_QUEUES = 3,
  parameter int QID_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_QUEUES-1:0] q_enable,
  input  logic                  notify_valid,
  input  logic [QID_W-1:0]      notify_qid,
  output logic                  evt_valid,
  output logic [QID_W-1:0]      evt_qid,
  input  logic                  evt_ready,
  output logic [CNT_W-1:0]      evt_count,
  output logic [NUM_QUEUES-1:0] pending,
  output logic [15:0]           drop_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                  state_q, state_d;
  logic [QID_W-1:0]        last_grant;
  logic [QID_W-1:0]        pick_qid;
  logic [NUM_QUEUES-1:0]   db_hit;
  logic [NUM_QUEUES-1:0]   evt_hit;
  logic [NUM_QUEUES-1:0]   pending_d;
  logic                    db_drop;
  logic                    load;
  logic                    accept;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode the doorbell and the offered queue into one-hot vectors; a doorbell
  // that hits no enabled in-range queue is a drop.
  always_comb begin
    db_hit  = '0;
    evt_hit = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      db_hit[q]  = notify_valid && q_enable[q] && (notify_qid == QID_W'(q));
      evt_hit[q] = (evt_qid == QID_W'(q));
    end
    db_drop = notify_valid && !(|db_hit);
  end

  // Round-robin pick: lowest pending queue above last_grant, else lowest overall.
  always_comb begin
    pick_qid = '0;
    for (int j = NUM_QUEUES - 1; j >= 0; j--) begin
      if (pending[j]) pick_qid = QID_W'(j);
    end
    for (int j = NUM_QUEUES - 1; j >= 0; j--) begin
      if (pending[j] && (QID_W'(j) > last_grant)) pick_qid = QID_W'(j);
    end
  end

  // FSM next state: IDLE loads an offer when anything is pending, OFFER waits for accept.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          load    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending flag update: disable clears, then a doorbell sets (wins over accept-clear).
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      pending_d[q] = pending[q];
      if (accept && evt_hit[q]) pending_d[q] = 1'b0;
      if (db_hit[q])            pending_d[q] = 1'b1;
      if (!q_enable[q])         pending_d[q] = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Offer register and round-robin pointer; an offer is never retracted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid  <= 1'b0;
      evt_qid    <= '0;
      last_grant <= QID_W'(NUM_QUEUES - 1);
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_qid   <= pick_qid;
    end else if (accept) begin
      evt_valid  <= 1'b0;
      last_grant <= evt_qid;
    end
  end

  // Pending flags and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= pending_d;
      if (db_drop) drop_cnt <= sat_inc16(drop_cnt);
    end
  end

`ifdef VIRTIO_NOTIFY_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_QUEUES];

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-queue coalesce counters; an accept restarts at 1 if a doorbell lands with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (!q_enable[q])              cnt_q[q] <= '0;
        else if (accept && evt_hit[q]) cnt_q[q] <= db_hit[q] ? CNT_W'(1) : '0;
        else if (db_hit[q])            cnt_q[q] <= sat_inc_cnt(cnt_q[q]);
      end
    end
  end

  // Live counter of the offered queue.
  always_comb begin
    evt_count = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (evt_hit[q]) evt_count = cnt_q[q];
    end
  end
`else
  assign evt_count = '0;
`endif

endmodule

// File: tb/tb_virtio_notify_arbiter.sv
// Bench for virtio_notify_arbiter: directed scenarios plus random traffic, checked
// against a queue-level reference model; accepted events go through a scoreboard.
module tb_virtio_notify_arbiter;

  localparam int NQ   = 3;
  localparam int QW   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NQ-1:0] q_enable = '0;
  logic          notify_valid = 1'b0;
  logic [QW-1:0] notify_qid = '0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [QW-1:0] evt_qid;
  logic [CW-1:0] evt_count;
  logic [NQ-1:0] pending;
  logic [15:0]   drop_cnt;

  virtio_notify_arbiter #(.NUM_QUEUES(NQ), .QID_W(QW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q_enable(q_enable),
    .notify_valid(notify_valid), .notify_qid(notify_qid),
    .evt_valid(evt_valid), .evt_qid(evt_qid), .evt_ready(evt_ready),
    .evt_count(evt_count), .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {int qid; int cnt;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  // Reference model state: set of pending queues, doorbell tallies, current offer.
  bit m_pend [NQ];
  int m_cnt  [NQ];
  int m_drop;
  bit m_off;
  int m_qid;
  int m_last;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int q);
`ifdef VIRTIO_NOTIFY_COUNT_EN
    return m_cnt[q];
`else
    return m_cnt[q] & 0;
`endif
  endfunction

  function automatic int pend_vec();
    int v = 0;
    for (int q = 0; q < NQ; q++) if (m_pend[q]) v |= (1 << q);
    return v;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) begin
      m_pend[q] = 1'b0;
      m_cnt[q]  = 0;
    end
    m_drop = 0;
    m_off  = 1'b0;
    m_qid  = 0;
    m_last = NQ - 1;
  endtask

  // One clock cycle, called at a falling edge: check outputs, drive inputs, advance model.
  task automatic step(input logic [NQ-1:0] en, input bit nv, input int nq, input bit rdy);
    bit   ok;
    bit   acc;
    int   aq;
    ev_t  ev;
    chk("evt_valid", int'(evt_valid), int'(m_off));
    if (m_off) begin
      chk("evt_qid", int'(evt_qid), m_qid);
      chk("evt_count", int'(evt_count), exp_cnt(m_qid));
    end
    chk("pending", int'(pending), pend_vec());
    chk("drop_cnt", int'(drop_cnt), m_drop);

    q_enable     = en;
    notify_valid = nv;
    notify_qid   = QW'(nq);
    evt_ready    = rdy;

    ok  = nv && (nq < NQ) && en[nq];
    acc = m_off && rdy;
    aq  = m_qid;
    if (acc) begin
      ev.qid = aq;
      ev.cnt = exp_cnt(aq);
      exp_q.push_back(ev);
      m_off  = 1'b0;
      m_last = aq;
    end else if (!m_off) begin
      for (int k = 1; k <= NQ; k++) begin
        int c;
        c = (m_last + k) % NQ;
        if (m_pend[c]) begin
          m_off = 1'b1;
          m_qid = c;
          break;
        end
      end
    end
    for (int q = 0; q < NQ; q++) begin
      if (!en[q]) begin
        m_pend[q] = 1'b0;
        m_cnt[q]  = 0;
      end else if (ok && nq == q) begin
        m_pend[q] = 1'b1;
        if (acc && aq == q)   m_cnt[q] = 1;
        else if (m_cnt[q] < CMAX) m_cnt[q] = m_cnt[q] + 1;
      end else if (acc && aq == q) begin
        m_pend[q] = 1'b0;
        m_cnt[q]  = 0;
      end
    end
    if (nv && !ok && m_drop < 65535) m_drop++;
    @(negedge clk);
  endtask

  // Monitor: on every DUT handshake pop the expected event and compare.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got qid %0d with nothing expected", evt_qid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_qid", int'(evt_qid), mon_e.qid);
          chk("acc_count", int'(evt_count), mon_e.cnt);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NQ-1:0] ren;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_qid", int'(evt_qid), 0);
    chk("rst_evt_count", int'(evt_count), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst_n = 1'b1;

    // Build an offer with all three queues pending, then reset asynchronously.
    step(3'b111, 1, 0, 0);
    step(3'b111, 1, 1, 0);
    step(3'b111, 1, 2, 0);
    step(3'b111, 1, 6, 0);
    step(3'b111, 0, 0, 0);
    chk("pre_rst_pending", int'(pending), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_evt_valid", int'(evt_valid), 0);
    chk("async_evt_qid", int'(evt_qid), 0);
    chk("async_evt_count", int'(evt_count), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_drop_cnt", int'(drop_cnt), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // First doorbell after reset goes to q1.
    step(3'b111, 1, 1, 0);
    repeat (3) step(3'b111, 0, 0, 1);

    // Burst to q0,q1,q2 with the consumer always ready.
    step(3'b111, 1, 0, 1);
    step(3'b111, 1, 1, 1);
    step(3'b111, 1, 2, 1);
    repeat (8) step(3'b111, 0, 0, 1);

    // Wrap: q2 offered, q0 pending, q2 re-kicked in its accept cycle.
    step(3'b111, 1, 2, 0);
    step(3'b111, 1, 0, 0);
    step(3'b111, 1, 2, 1);
    repeat (6) step(3'b111, 0, 0, 1);

    // Set-wins collision on q1.
    step(3'b111, 1, 1, 0);
    step(3'b111, 0, 0, 0);
    step(3'b111, 1, 1, 1);
    repeat (5) step(3'b111, 0, 0, 1);

    // Drops: out-of-range id and disabled queue.
    step(3'b111, 1, 5, 0);
    step(3'b110, 1, 0, 0);
    step(3'b111, 0, 0, 0);

    // Disabling the offered queue keeps the offer but clears its flag.
    step(3'b111, 1, 0, 0);
    step(3'b111, 0, 0, 0);
    step(3'b110, 0, 0, 0);
    step(3'b110, 0, 0, 1);
    repeat (3) step(3'b111, 0, 0, 1);

    // Backpressure on q2 with four more doorbells while held.
    step(3'b111, 1, 2, 0);
    step(3'b111, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(3'b111, i < 4, 2, 0);
    repeat (3) step(3'b111, 0, 0, 1);

    // Counter saturation on q2.
    for (int i = 0; i < CMAX + 5; i++) step(3'b111, 1, 2, 0);
    repeat (4) step(3'b111, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ren = ($urandom_range(0, 15) == 0) ? NQ'($urandom) : '1;
      step(ren, $urandom_range(0, 1) == 1, int'($urandom_range(0, 5)),
           $urandom_range(0, 3) != 0);
    end
    repeat (4) step(3'b111, 0, 0, 1);

    // Drive drop_cnt into saturation.
    repeat (65540) step(3'b111, 1, 7, 0);
    repeat (4) step(3'b111, 0, 0, 1);
    chk("drop_sat", int'(drop_cnt), 65535);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
